// File: rtl/gray_sequence_monitor.sv
// Gray sequence monitor: decodes sampled Gray codes, classifies each step as hold/up/down/illegal,
// tracks direction, wrap and error count, and reports lock status through a small FSM.
module gray_sequence_monitor #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WIDTH-1:0]     gray_in,
  output logic [WIDTH-1:0]     bin_out,
  output logic                 dir_out,
  output logic                 step_err,
  output logic                 wrap,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 locked
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] RESYNC = 2'd2;

  localparam logic [WIDTH-1:0]     BIN_MAX = '1;
  localparam logic [WIDTH-1:0]     STEP_UP = WIDTH'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     bin_q, bin_d;
  logic                 dir_q, dir_d;
  logic                 step_err_q, step_err_d;
  logic                 wrap_q, wrap_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic                 good_q, good_d;
  logic                 locked_q;

  logic [WIDTH-1:0]     bin_new;
  logic [WIDTH-1:0]     diff;
  logic                 is_hold, is_up, is_down;

  // Each binary bit is the XOR of the Gray bits at and above it.
  always_comb begin
    bin_new = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      bin_new[i] = ^(gray_in >> i);
    end
  end

  always_comb begin
    diff    = bin_new - bin_q;
    is_hold = (diff == '0);
    is_up   = (diff == STEP_UP);
    is_down = (diff == BIN_MAX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      dir_q      <= 1'b1;
      step_err_q <= 1'b0;
      wrap_q     <= 1'b0;
      err_q      <= '0;
      good_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      dir_q      <= dir_d;
      step_err_q <= step_err_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
      good_q     <= good_d;
      locked_q   <= (state_d == TRACK);
    end
  end

  // Next-state and output decisions; the previous reference is always the current bin_q.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    dir_d      = dir_q;
    step_err_d = 1'b0;
    wrap_d     = 1'b0;
    err_d      = err_q;
    good_d     = good_q;

    if (valid) begin
      case (state_q)
        IDLE: begin
          bin_d   = bin_new;
          good_d  = 1'b0;
          state_d = TRACK;
        end
        TRACK, RESYNC: begin
          if (is_up || is_down) begin
            bin_d  = bin_new;
            dir_d  = is_up;
            wrap_d = is_up ? (bin_q == BIN_MAX) : (bin_q == '0);
            if (state_q == RESYNC) begin
              good_d = ~good_q;
              if (good_q) begin
                state_d = TRACK;
              end
            end
          end else if (!is_hold) begin
            step_err_d = 1'b1;
            bin_d      = bin_new;
            good_d     = 1'b0;
            state_d    = RESYNC;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign bin_out   = bin_q;
  assign dir_out   = dir_q;
  assign step_err  = step_err_q;
  assign wrap      = wrap_q;
  assign err_count = err_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_gray_sequence_monitor.sv
// Bench for gray_sequence_monitor: directed scenarios then random traffic, all
// checked against an arithmetic reference model of the step rules.
module tb_gray_sequence_monitor;

  localparam int W    = 3;
  localparam int E    = 4;
  localparam int N    = 1 << W;
  localparam int EMAX = (1 << E) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         dir_out;
  logic         step_err;
  logic         wrap;
  logic [E-1:0] err_count;
  logic         locked;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  bit m_have_ref;
  bit m_locked;
  int m_good;
  int m_bin;
  int m_dir;
  int m_err;
  int m_step_err;
  int m_wrap;

  gray_sequence_monitor #(.WIDTH(W), .ERR_CNT_W(E)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid    (valid),
    .gray_in  (gray_in),
    .bin_out  (bin_out),
    .dir_out  (dir_out),
    .step_err (step_err),
    .wrap     (wrap),
    .err_count(err_count),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % N;
  endfunction

  // Decode by searching for the binary value whose Gray image matches.
  function automatic int from_gray(input int g);
    for (int b = 0; b < N; b++) begin
      if (to_gray(b) == g) return b;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bin_out"},   32'(bin_out),   32'(m_bin));
    check({tag, ".dir_out"},   32'(dir_out),   32'(m_dir));
    check({tag, ".step_err"},  32'(step_err),  32'(m_step_err));
    check({tag, ".wrap"},      32'(wrap),      32'(m_wrap));
    check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
    check({tag, ".locked"},    32'(locked),    32'(m_locked));
  endtask

  task automatic model_reset();
    m_have_ref = 0; m_locked = 0; m_good = 0;
    m_bin = 0; m_dir = 1; m_err = 0; m_step_err = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit v, input int g);
    int b, d;
    m_step_err = 0;
    m_wrap     = 0;
    if (!v) return;
    b = from_gray(g);
    if (!m_have_ref) begin
      m_have_ref = 1;
      m_bin      = b;
      m_locked   = 1;
      return;
    end
    d = (b - m_bin + N) % N;
    if (d == 0) return;
    if (d == 1 || d == N - 1) begin
      m_wrap = (d == 1) ? (m_bin == N - 1) : (m_bin == 0);
      m_dir  = (d == 1);
      m_bin  = b;
      if (!m_locked) begin
        m_good++;
        if (m_good == 2) begin
          m_locked = 1;
          m_good   = 0;
        end
      end
    end else begin
      m_step_err = 1;
      m_err      = (m_err < EMAX) ? m_err + 1 : EMAX;
      m_bin      = b;
      m_locked   = 0;
      m_good     = 0;
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic apply(input bit v, input int b, input string tag);
    @(negedge clk);
    valid   = v;
    gray_in = W'(to_gray(b));
    @(posedge clk);
    #1;
    model_step(v, to_gray(b));
    check_all(tag);
  endtask

  // Assert reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    valid = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int b, r;
    model_reset();
    #12;
    check_all("por");
    @(negedge clk);
    reset = 1'b1;

    // Up count with wrap on 7->0
    for (int i = 0; i <= N; i++) apply(1'b1, i % N, "up");

    // Down: hold at 0, then 0->7 (wrap) and 7->6
    apply(1'b1, 0, "down_hold");
    apply(1'b1, 7, "down_wrap");
    apply(1'b1, 6, "down");

    // Walk down to 2, then repeat 011 with valid gaps
    for (int i = 5; i >= 2; i--) apply(1'b1, i, "walk");
    for (int i = 0; i < 6; i++) apply(i[0] == 1'b0, 2, "hold_gap");

    // Illegal jump 0->3, resync via 4,5, then illegal again mid-resync
    apply(1'b1, 1, "to0");
    apply(1'b1, 0, "to0");
    apply(1'b1, 3, "illegal");
    apply(1'b1, 4, "resync1");
    apply(1'b1, 5, "resync2");
    apply(1'b1, 0, "illegal2");
    apply(1'b1, 1, "resync_a");
    apply(1'b1, 4, "illegal_in_resync");
    apply(1'b1, 4, "resync_hold");

    // Saturation: 17 consecutive jumps of distance 4
    for (int i = 0; i < 17; i++) apply(1'b1, (i % 2 == 0) ? 0 : 4, "sat");

    // Mid-sequence reset, then first edge after release accepts a sample
    apply(1'b1, 5, "pre_rst");
    do_reset("mid_rst");
    apply(1'b1, 6, "post_rst");

    // Random traffic, mostly legal steps
    for (int i = 0; i < 400; i++) begin
      if (i % 150 == 149) do_reset("rand_rst");
      r = int'($urandom_range(0, 9));
      if (r < 4)      b = (m_bin + 1) % N;
      else if (r < 7) b = (m_bin + N - 1) % N;
      else if (r < 8) b = m_bin;
      else            b = int'($urandom_range(0, N - 1));
      apply($urandom_range(0, 3) != 0, b, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_sequence_monitor.md
# gray_sequence_monitor

Downstream consumer of the 3-bit Gray code counter. It samples the counter's Gray output, converts it to binary, and checks that every change is a legal single step (binary ±1 modulo 2^WIDTH). From the observed step direction it derives count direction, flags wrap-around, and counts illegal jumps. A lock state machine reports whether the incoming sequence is trustworthy, so checker logic and the waveform bench can gate on `locked`.

## Interface
- `WIDTH`, 3, Gray/binary code width.
- `ERR_CNT_W`, 4, width of the saturating error counter.

- `clk`  in  1  rising-edge clock, shared with the counter.
- `reset`  in  1  asynchronous, active-low reset.
- `valid`  in  1  sample strobe: `gray_in` is taken only on edges where `valid`=1.
- `gray_in`  in  WIDTH  Gray code from the counter's `out`.
- `bin_out`  out  WIDTH  binary value of the last accepted sample.
- `dir_out`  out  1  direction of the last legal step: 1=up, 0=down.
- `step_err`  out  1  one-cycle pulse on an illegal jump.
- `wrap`  out  1  one-cycle pulse on a legal step from max to 0 (up) or from 0 to max (down).
- `err_count`  out  ERR_CNT_W  number of illegal jumps; saturates at all-ones.
- `locked`  out  1  high only in state TRACK.

## Operation
- Conversion: `b[WIDTH-1]=g[WIDTH-1]`; `b[i]=b[i+1]^g[i]`. The conversion is combinational and its result is registered into `bin_out`.
- Step classification for each accepted sample, using `d = (b_new - b_prev) mod 2^WIDTH`:
  - HOLD: d=0.
  - UP: d=1.
  - DOWN: d=2^WIDTH-1.
  - ILLEGAL: any other value of d.
- States:
  - IDLE: no reference yet. The first valid sample loads `b_prev`/`bin_out` with no classification. Go to TRACK.
  - TRACK: HOLD leaves everything unchanged. UP/DOWN updates `bin_out` and `dir_out`, and pulses `wrap` on a boundary crossing. ILLEGAL pulses `step_err`, increments `err_count`, updates `bin_out` (new reference) and goes to RESYNC. `dir_out` is unchanged.
  - RESYNC: UP/DOWN updates outputs as in TRACK and increments a 1-bit `good` counter. The second consecutive legal step returns to TRACK. ILLEGAL pulses `step_err`, increments `err_count`, clears `good` and stays in RESYNC. HOLD changes nothing and does not clear `good`.
- `err_count` holds at 2^ERR_CNT_W-1; further errors still pulse `step_err`.
- With `valid`=0, all state is held and the pulses are 0.

## Timing
- Reset (asynchronous assert, any time, including mid-sequence):
  - state goes to IDLE.
  - `bin_out`=0, `dir_out`=1, `step_err`=0, `wrap`=0, `err_count`=0, `locked`=0, `good`=0.
- Latency is one cycle. A sample taken at edge N appears on `bin_out`, `dir_out`, `step_err` and `wrap` after edge N.
- `locked` rises after the edge that accepts the first sample.
- `locked` falls after the edge that accepts an ILLEGAL sample.
- Release of reset is synchronous to `clk`. The first edge with `reset`=1 may accept a sample.
- `step_err` and `wrap` are never both 1. Each is high for exactly one cycle per event, including back-to-back events on consecutive valid edges.

## Test plan
- Reset → all outputs match the reset values, state IDLE. Assert reset mid-count → outputs clear immediately without waiting for a clock edge.
- Up sequence, `valid`=1: 000,001,011,010,110,111,101,100,000 → `bin_out` 0..7 then 0, `dir_out`=1, `wrap` only on the 100→000 step, `locked`=1 from the 2nd cycle, `err_count`=0.
- Down sequence from 000: 000,100,101 → `bin_out` 0,7,6, `dir_out`=0, `wrap` on 0→7.
- Hold and `valid` gaps: repeat 011 three times with `valid` toggling → `bin_out`=2 held, no pulses, `locked` stays 1.
- Illegal jump 000→010 (binary 0→3) → `step_err` pulse, `err_count`=1, `locked`=0, `bin_out`=3. Then 110,111 (binary 4,5) → `locked`=1 after the second step. Jump again during RESYNC → `err_count`=2, still unlocked.
- Seventeen consecutive illegal jumps with `ERR_CNT_W`=4 → `err_count` stops at 15, `step_err` still pulses every time.
